// File: rtl/stopwatch_core_param.sv
// mm:ss stopwatch/timer core: up/down BCD count, lap freeze, per-digit adjust while paused
// and a registered, multiplexed active-low 7-segment drive. Single clock, internal enables only.
module stopwatch_core_param #(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned TICK_HZ      = 1,
   parameter int unsigned SCAN_HZ      = 400,
   parameter int unsigned MIN_TENS_MAX = 5,
   parameter bit          SATURATE     = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pause_stb,
   input  logic        lap_stb,
   input  logic        dir,
   input  logic [1:0]  adj_sel,
   input  logic        adj_stb,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        running,
   output logic        done,
   output logic        blink_led,
   output logic [15:0] bcd
);

   localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned HALF_DIV = CLK_HZ / (2 * TICK_HZ);
   localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TW-1:0] TICK_TC = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HALF_TC = HW'(HALF_DIV - 1);
   localparam logic [SW-1:0] SCAN_TC = SW'(SCAN_DIV - 1);
   localparam logic [3:0]    M10_MAX = 4'(MIN_TENS_MAX);

   typedef enum logic {StPaused = 1'b0, StRunning = 1'b1} state_e;

   state_e          state_q, state_d;
   logic [3:0]      s1_q, s1_d, s10_q, s10_d, m1_q, m1_d, m10_q, m10_d;
   logic [TW-1:0]   tick_div_q, tick_div_d;
   logic [HW-1:0]   half_div_q, half_div_d;
   logic [SW-1:0]   scan_div_q, scan_div_d;
   logic [1:0]      idx_q, idx_d;
   logic            blink_q, blink_d;
   logic            done_q, done_d;
   logic            freeze_q, freeze_d;
   logic [15:0]     lap_q, lap_d;
   logic [6:0]      seg_q, seg_d;
   logic [3:0]      an_q, an_d;

   logic        tick;
   logic        at_zero, at_top;
   logic [15:0] live, disp;
   logic [3:0]  digit;
   logic        blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign running   = (state_q == StRunning);
   assign live      = {m10_q, m1_q, s10_q, s1_q};
   assign bcd       = live;
   assign seg       = seg_q;
   assign an        = an_q;
   assign done      = done_q;
   assign blink_led = blink_q;
   assign at_zero   = (live == 16'h0000);
   assign at_top    = (m10_q == M10_MAX) && (m1_q == 4'd9) && (s10_q == 4'd5) && (s1_q == 4'd9);
   assign tick      = running && (tick_div_q == TICK_TC);

   // Dividers: the tick divider holds its phase while paused, the half-tick one free-runs.
   always_comb begin
      tick_div_d = tick_div_q;
      half_div_d = half_div_q;
      blink_d    = blink_q;
      scan_div_d = scan_div_q;
      idx_d      = idx_q;
      if (running) begin
         tick_div_d = tick ? '0 : tick_div_q + 1'b1;
      end
      if (half_div_q == HALF_TC) begin
         half_div_d = '0;
         blink_d    = ~blink_q;
      end else begin
         half_div_d = half_div_q + 1'b1;
      end
      if (scan_div_q == SCAN_TC) begin
         scan_div_d = '0;
         idx_d      = idx_q + 2'd1;
      end else begin
         scan_div_d = scan_div_q + 1'b1;
      end
   end

   // Run state and BCD count; a terminal tick overrides any pause toggle in the same cycle.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      s1_d    = s1_q;
      s10_d   = s10_q;
      m1_d    = m1_q;
      m10_d   = m10_q;
      if (pause_stb && !(dir && at_zero)) begin
         state_d = running ? StPaused : StRunning;
      end
      if (tick) begin
         if (!dir) begin
            done_d = at_top;
            if (at_top) begin
               if (SATURATE) begin
                  state_d = StPaused;
               end else begin
                  s1_d  = '0;
                  s10_d = '0;
                  m1_d  = '0;
                  m10_d = '0;
               end
            end else if (s1_q != 4'd9) begin
               s1_d = s1_q + 4'd1;
            end else begin
               s1_d = '0;
               if (s10_q != 4'd5) begin
                  s10_d = s10_q + 4'd1;
               end else begin
                  s10_d = '0;
                  if (m1_q != 4'd9) begin
                     m1_d = m1_q + 4'd1;
                  end else begin
                     m1_d  = '0;
                     m10_d = m10_q + 4'd1;
                  end
               end
            end
         end else begin
            done_d = at_zero;
            if (at_zero) begin
               state_d = StPaused;
            end else if (s1_q != 4'd0) begin
               s1_d = s1_q - 4'd1;
            end else begin
               s1_d = 4'd9;
               if (s10_q != 4'd0) begin
                  s10_d = s10_q - 4'd1;
               end else begin
                  s10_d = 4'd5;
                  if (m1_q != 4'd0) begin
                     m1_d = m1_q - 4'd1;
                  end else begin
                     m1_d  = 4'd9;
                     m10_d = m10_q - 4'd1;
                  end
               end
            end
         end
      end else if (adj_stb && !running) begin
         unique case (adj_sel)
            2'd0: s1_d  = (s1_q  >= 4'd9)    ? 4'd0 : s1_q  + 4'd1;
            2'd1: s10_d = (s10_q >= 4'd5)    ? 4'd0 : s10_q + 4'd1;
            2'd2: m1_d  = (m1_q  >= 4'd9)    ? 4'd0 : m1_q  + 4'd1;
            2'd3: m10_d = (m10_q >= M10_MAX) ? 4'd0 : m10_q + 4'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      freeze_d = freeze_q;
      lap_d    = lap_q;
      if (lap_stb) begin
         freeze_d = ~freeze_q;
         if (!freeze_q) begin
            lap_d = live;
         end
      end
   end

   // Display path is registered against the upcoming scan slot so an and seg move together.
   always_comb begin
      disp = freeze_q ? lap_q : live;
      unique case (idx_d)
         2'd0:    digit = disp[3:0];
         2'd1:    digit = disp[7:4];
         2'd2:    digit = disp[11:8];
         default: digit = disp[15:12];
      endcase
      blank = !running && (idx_d == adj_sel) && !blink_q;
      seg_d = blank ? 7'h7F : seg_decode(digit);
      an_d  = ~(4'b0001 << idx_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StPaused;
         s1_q       <= '0;
         s10_q      <= '0;
         m1_q       <= '0;
         m10_q      <= '0;
         tick_div_q <= '0;
         half_div_q <= '0;
         scan_div_q <= '0;
         idx_q      <= '0;
         blink_q    <= 1'b0;
         done_q     <= 1'b0;
         freeze_q   <= 1'b0;
         lap_q      <= '0;
         seg_q      <= 7'h40;
         an_q       <= 4'b1110;
      end else begin
         state_q    <= state_d;
         s1_q       <= s1_d;
         s10_q      <= s10_d;
         m1_q       <= m1_d;
         m10_q      <= m10_d;
         tick_div_q <= tick_div_d;
         half_div_q <= half_div_d;
         scan_div_q <= scan_div_d;
         idx_q      <= idx_d;
         blink_q    <= blink_d;
         done_q     <= done_d;
         freeze_q   <= freeze_d;
         lap_q      <= lap_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

endmodule

// File: tb/tb_stopwatch_core_param.sv
// Scoreboard bench for stopwatch_core_param: a seconds-based reference model predicts every
// cycle's outputs for a wrapping and a saturating instance driven by the same stimulus.
module tb_stopwatch_core_param;

   localparam int TD  = 10;   // clocks per count tick
   localparam int HD  = 5;    // clocks per blink half-period
   localparam int SD  = 2;    // clocks per scan slot
   localparam int MT  = 5;
   localparam int TOP = (MT + 1) * 600 - 1;

   typedef struct packed {
      int         secs;
      int         lapv;
      int         tdiv;
      int         hdiv;
      int         sdiv;
      int         idx;
      bit         run;
      bit         frz;
      bit         blink;
      bit         done;
      logic [3:0] an;
      logic [6:0] seg;
   } model_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pause_stb = 1'b0, lap_stb = 1'b0, dir = 1'b0, adj_stb = 1'b0;
   logic [1:0] adj_sel = 2'd0;

   logic [6:0]  seg0, seg1;
   logic [3:0]  an0, an1;
   logic        run0, run1, done0, done1, blink0, blink1;
   logic [15:0] bcd0, bcd1;

   int n_cmp = 0;
   int n_bad = 0;

   model_t m0 = '0, m1 = '0, n0, n1;
   model_t q0[$], q1[$];

   always #5 clk = ~clk;

   stopwatch_core_param #(
      .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .MIN_TENS_MAX(MT), .SATURATE(1'b0)
   ) u_wrap (
      .clk(clk), .rst(rst), .pause_stb(pause_stb), .lap_stb(lap_stb), .dir(dir),
      .adj_sel(adj_sel), .adj_stb(adj_stb), .seg(seg0), .an(an0), .running(run0),
      .done(done0), .blink_led(blink0), .bcd(bcd0)
   );

   stopwatch_core_param #(
      .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .MIN_TENS_MAX(MT), .SATURATE(1'b1)
   ) u_sat (
      .clk(clk), .rst(rst), .pause_stb(pause_stb), .lap_stb(lap_stb), .dir(dir),
      .adj_sel(adj_sel), .adj_stb(adj_stb), .seg(seg1), .an(an1), .running(run1),
      .done(done1), .blink_led(blink1), .bcd(bcd1)
   );

   function automatic logic [15:0] to_bcd(input int s);
      return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
   endfunction

   function automatic logic [6:0] seg_pat(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;  4'd3: return 7'h30;
         4'd4: return 7'h19;  4'd5: return 7'h12;  4'd6: return 7'h02;  4'd7: return 7'h78;
         4'd8: return 7'h00;  4'd9: return 7'h10;  default: return 7'h7F;
      endcase
   endfunction

   function automatic model_t step(input model_t o, input bit sat, input logic r, input logic p,
                                   input logic l, input logic d, input logic a,
                                   input logic [1:0] sel);
      model_t n;
      bit tick;
      int dig[4];
      int lim[4];
      logic [15:0] dsp;
      n = o;
      if (r) begin
         n = '0;
         n.an = 4'b1110;
         n.seg = 7'h40;
         return n;
      end
      tick = o.run && (o.tdiv == TD - 1);
      if (o.run) n.tdiv = tick ? 0 : o.tdiv + 1;
      if (o.hdiv == HD - 1) begin
         n.hdiv = 0;
         n.blink = !o.blink;
      end else begin
         n.hdiv = o.hdiv + 1;
      end
      n.done = 1'b0;
      if (p && !(d && o.secs == 0)) n.run = !o.run;
      if (tick) begin
         if (!d) begin
            if (o.secs == TOP) begin
               n.done = 1'b1;
               if (sat) n.run = 1'b0;
               else n.secs = 0;
            end else begin
               n.secs = o.secs + 1;
            end
         end else if (o.secs == 0) begin
            n.done = 1'b1;
            n.run = 1'b0;
         end else begin
            n.secs = o.secs - 1;
         end
      end else if (a && !o.run) begin
         dig[0] = o.secs % 10;          lim[0] = 10;
         dig[1] = (o.secs % 60) / 10;   lim[1] = 6;
         dig[2] = (o.secs / 60) % 10;   lim[2] = 10;
         dig[3] = o.secs / 600;         lim[3] = MT + 1;
         dig[sel] = (dig[sel] + 1) % lim[sel];
         n.secs = dig[3] * 600 + dig[2] * 60 + dig[1] * 10 + dig[0];
      end
      if (l) begin
         if (!o.frz) n.lapv = o.secs;
         n.frz = !o.frz;
      end
      if (o.sdiv == SD - 1) begin
         n.sdiv = 0;
         n.idx = (o.idx + 1) % 4;
      end else begin
         n.sdiv = o.sdiv + 1;
      end
      n.an = ~(4'b0001 << n.idx);
      dsp = o.frz ? to_bcd(o.lapv) : to_bcd(o.secs);
      if (!o.run && n.idx == int'(sel) && !o.blink) n.seg = 7'h7F;
      else n.seg = seg_pat(dsp[n.idx*4 +: 4]);
      return n;
   endfunction

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input model_t e, input logic [15:0] b,
                            input logic r, input logic dn, input logic bl,
                            input logic [3:0] a, input logic [6:0] s);
      cmp({tag, ".bcd"}, b, to_bcd(e.secs));
      cmp({tag, ".running"}, 16'(r), 16'(e.run));
      cmp({tag, ".done"}, 16'(dn), 16'(e.done));
      cmp({tag, ".blink_led"}, 16'(bl), 16'(e.blink));
      cmp({tag, ".an"}, 16'(a), 16'(e.an));
      cmp({tag, ".seg"}, 16'(s), 16'(e.seg));
   endtask

   // Reference model: predicts the post-edge outputs and queues them.
   always_comb n0 = step(m0, 1'b0, rst, pause_stb, lap_stb, dir, adj_stb, adj_sel);
   always_comb n1 = step(m1, 1'b1, rst, pause_stb, lap_stb, dir, adj_stb, adj_sel);

   always @(posedge clk) begin
      m0 <= n0;
      m1 <= n1;
      q0.push_back(n0);
      q1.push_back(n1);
   end

   // Monitor: every cycle presents a full output set, compared against the oldest prediction.
   always @(negedge clk) begin
      model_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         check_all("wrap", e, bcd0, run0, done0, blink0, an0, seg0);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check_all("sat", e, bcd1, run1, done1, blink1, an1, seg1);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic pulse_pause();
      pause_stb = 1'b1;
      @(negedge clk);
      pause_stb = 1'b0;
   endtask

   task automatic pulse_lap();
      lap_stb = 1'b1;
      @(negedge clk);
      lap_stb = 1'b0;
   endtask

   task automatic adj(input logic [1:0] s, input int n);
      adj_sel = s;
      repeat (n) begin
         adj_stb = 1'b1;
         @(negedge clk);
         adj_stb = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      idle(2);
      cmp("reset.an", 16'(an0), 16'(4'b1110));
      cmp("reset.seg", 16'(seg0), 16'(7'h40));
      rst = 1'b0;

      // Sixty ticks from 00:00 reach 01:00.
      adj_sel = 2'd1;
      pulse_pause();
      idle(600);
      cmp("run60.bcd", bcd0, 16'h0100);
      cmp("run60.running", 16'(run0), 16'h0001);

      // Top of range: wrap on one instance, saturate on the other.
      pulse_pause();
      adj(2'd3, 5);
      adj(2'd2, 8);
      adj(2'd1, 5);
      adj(2'd0, 8);
      cmp("top.preset", bcd0, 16'h5958);
      pulse_pause();
      idle(22);
      cmp("top.wrap.bcd", bcd0, 16'h0000);
      cmp("top.wrap.running", 16'(run0), 16'h0001);
      cmp("top.sat.bcd", bcd1, 16'h5959);
      cmp("top.sat.running", 16'(run1), 16'h0000);

      // Down-count to zero stops; a later pause strobe cannot restart it.
      do_reset();
      adj(2'd0, 3);
      dir = 1'b1;
      pulse_pause();
      idle(45);
      cmp("down.bcd", bcd0, 16'h0000);
      cmp("down.running", 16'(run0), 16'h0000);
      pulse_pause();
      idle(2);
      cmp("down.restart", 16'(run0), 16'h0000);
      dir = 1'b0;

      // s10 adjust wraps at 6; adjust is ignored while running.
      do_reset();
      adj(2'd1, 7);
      cmp("adj.s10", bcd0, 16'h0010);
      pulse_pause();
      adj(2'd1, 2);
      cmp("adj.running", bcd0, 16'h0010);

      // Lap freeze at 00:05 while counting on to 00:09.
      do_reset();
      adj(2'd0, 5);
      pulse_pause();
      pulse_lap();
      idle(45);
      cmp("lap.live", bcd0, 16'h0009);
      pulse_lap();
      idle(4);

      // Randomised phase, including occasional mid-run resets.
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom_range(0, 599) == 0);
         pause_stb = ($urandom_range(0, 29) == 0);
         lap_stb   = ($urandom_range(0, 39) == 0);
         adj_stb   = ($urandom_range(0, 5) == 0);
         adj_sel   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) dir = ~dir;
         @(negedge clk);
      end
      rst = 1'b0;
      pause_stb = 1'b0;
      lap_stb = 1'b0;
      adj_stb = 1'b0;
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
